// File: rtl/board_input_ctrl_pkg.sv
// rtl/board_input_ctrl_pkg.sv - register offsets, button indices and helpers shared with the CPU side
package board_input_ctrl_pkg;

    localparam logic [1:0] REG_SW  = 2'd0;
    localparam logic [1:0] REG_BTN = 2'd1;
    localparam logic [1:0] REG_EVT = 2'd2;
    localparam logic [1:0] REG_TS  = 2'd3;

    localparam int BTN_C = 0;
    localparam int BTN_R = 1;
    localparam int BTN_L = 2;
    localparam int BTN_D = 3;
    localparam int BTN_U = 4;

    localparam int NUM_BTN = BTN_U + 1;
    localparam int NUM_SW  = 16;
    localparam int NUM_IN  = NUM_BTN + NUM_SW;

    // Lowest set index wins when several buttons rise on the same edge.
    function automatic logic [2:0] lowest_btn(input logic [NUM_BTN-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/board_input_ctrl_debounce_bit.sv
// rtl/board_input_ctrl_debounce_bit.sv - 2-FF synchroniser plus stability counter for one board input
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the accepted level restarts the count, rejecting glitches.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/board_input_ctrl.sv
// rtl/board_input_ctrl.sv - debounced buttons/switches, press events, press timestamps and CPU read port
module board_input_ctrl
    import board_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TS_WIDTH        = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_raw,
    input  logic [NUM_SW-1:0]   sw_raw,
    input  logic                rd_en,
    input  logic [1:0]          rd_sel,
    output logic [31:0]         rd_data,
    output logic [NUM_BTN-1:0]  btn_level,
    output logic                evt_pending
);

    logic [NUM_IN-1:0]   raw_all;
    logic [NUM_IN-1:0]   stable_all;
    logic [NUM_SW-1:0]   sw_stable;
    logic [NUM_BTN-1:0]  btn_stable;
    logic [NUM_BTN-1:0]  btn_stable_d;
    logic [NUM_BTN-1:0]  rise;
    logic [NUM_BTN-1:0]  evt;
    logic                clr;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] last_ts;
    logic [2:0]          last_id;
    logic [23:0]         last_ts_ext;
    logic [31:0]         rd_next;

    assign raw_all = {btn_raw, sw_raw};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_all[i]),
            .level (stable_all[i])
        );
    end

    assign sw_stable  = stable_all[NUM_SW-1:0];
    assign btn_stable = stable_all[NUM_IN-1:NUM_SW];
    assign btn_level  = btn_stable;

    // Only presses matter; releases never create events.
    assign rise        = btn_stable & ~btn_stable_d;
    assign clr         = rd_en && (rd_sel == REG_EVT);
    assign evt_pending = |evt;
    assign last_ts_ext = 24'(last_ts);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_stable_d <= '0;
            evt          <= '0;
        end else begin
            btn_stable_d <= btn_stable;
            // A press landing on the clearing read survives into the next value.
            evt          <= (clr ? '0 : evt) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts      <= '0;
            last_ts <= '0;
            last_id <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (|rise) begin
                last_ts <= ts;
                last_id <= lowest_btn(rise);
            end
        end
    end

    always_comb begin
        rd_next = '0;
        case (rd_sel)
            REG_SW:  rd_next = {16'b0, sw_stable};
            REG_BTN: rd_next = {27'b0, btn_stable};
            REG_EVT: rd_next = {27'b0, evt};
            REG_TS:  rd_next = {5'b0, last_id, last_ts_ext};
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end
    end

endmodule
